ntt_scheduler: RTL and testbench

- Sequences one in-place forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) over an N-coefficient dual-port memory using a single butterfly unit.
- Generates read/write address pairs, twiddle-ROM index and ct_mode for the butterfly, and tracks the butterfly's pipeline latency.
- Drains between stages so each stage only reads finished results of the previous stage.
- Sits between the top-level polynomial controller (start/done) and the coefficient RAM, twiddle ROM and butterfly unit.

---
 rtl/ntt_scheduler.sv | 141 ++++++++++++++
 tb/tb_ntt_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_scheduler.sv
// In-place NTT sequencer: issues one butterfly per cycle (CT forward / GS inverse),
// drains the butterfly pipeline between stages and mirrors read addresses into write addresses.
module ntt_scheduler #(
  parameter int LOGN    = 8,
  parameter int BFU_LAT = 4,
  parameter int ADDR_W  = LOGN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [ADDR_W-1:0] tw_addr_o,
  output logic              ct_mode_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o
);

  localparam int DEPTH = 1 + BFU_LAT;
  localparam int SW    = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
  localparam logic [LOGN-2:0] B_LAST = (LOGN-1)'((1 << (LOGN - 1)) - 1);
  localparam logic [DW-1:0]   D_LAST = DW'(DEPTH - 1);

  logic [1:0]      state;
  logic            mode_q;
  logic [SW-1:0]   s_q;
  logic [LOGN-2:0] b_q;
  logic [DW-1:0]   d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
      s_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            mode_q <= mode_i;
            s_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (b_q == B_LAST) begin
            d_q   <= '0;
            state <= ST_DRAIN;
          end else begin
            b_q <= b_q + (LOGN-1)'(1);
          end
        end
        ST_DRAIN: begin
          // wait until the last butterfly of this stage has been written back
          if (d_q == D_LAST) begin
            if (s_q == S_LAST) begin
              state <= ST_DONE;
            end else begin
              s_q   <= s_q + SW'(1);
              b_q   <= '0;
              state <= ST_RUN;
            end
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: address generation from (stage, butterfly) counters
  logic              rd_en;
  logic [SW-1:0]     k;
  logic [ADDR_W-1:0] len, bx, g, o, a_addr, b_addr, tw;

  always_comb begin
    rd_en  = (state == ST_RUN);
    k      = mode_q ? s_q : (S_LAST - s_q);
    len    = ADDR_W'(1) << k;
    bx     = ADDR_W'(b_q);
    g      = bx >> k;
    o      = bx & (len - ADDR_W'(1));
    a_addr = ((g << k) << 1) | o;
    b_addr = a_addr | len;
    tw     = mode_q ? (({ADDR_W{1'b1}} >> s_q) - g) : ((ADDR_W'(1) << s_q) + g);
    if (!rd_en) begin
      a_addr = '0;
      b_addr = '0;
      tw     = '0;
    end
  end

  assign busy_o      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done_o      = (state == ST_DONE);
  assign ct_mode_o   = (state != ST_IDLE) & ~mode_q;
  assign rd_en_o     = rd_en;
  assign rd_addr_a_o = a_addr;
  assign rd_addr_b_o = b_addr;
  assign tw_addr_o   = tw;

  // Stages p1..pDEPTH: write addresses follow the read through RAM and butterfly latency
  logic [DEPTH-1:0]  vld_p;
  logic [ADDR_W-1:0] wr_a_p [DEPTH];
  logic [ADDR_W-1:0] wr_b_p [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_p <= '0;
    else       vld_p <= {vld_p[DEPTH-2:0], rd_en};
  end

  always_ff @(posedge clk_i) begin
    wr_a_p[0] <= a_addr;
    wr_b_p[0] <= b_addr;
    for (int i = 1; i < DEPTH; i++) begin
      wr_a_p[i] <= wr_a_p[i-1];
      wr_b_p[i] <= wr_b_p[i-1];
    end
  end

  assign wr_en_o     = vld_p[DEPTH-1];
  assign wr_addr_a_o = vld_p[DEPTH-1] ? wr_a_p[DEPTH-1] : '0;
  assign wr_addr_b_o = vld_p[DEPTH-1] ? wr_b_p[DEPTH-1] : '0;

endmodule

// File: tb/tb_ntt_scheduler.sv
// Bench for ntt_scheduler: cycle-level reference schedule, spot-check table,
// read-order scoreboard against nested-loop NTT ordering, and memory write bookkeeping.
`timescale 1ns/1ps
module tb_ntt_scheduler;
  localparam int LOGN = 8, BFU_LAT = 4, ADDR_W = LOGN;
  localparam int N = 1 << LOGN, HALF = N / 2, D = 1 + BFU_LAT, P = HALF + D, TOT = LOGN * P;
  localparam int VW = 5 * ADDR_W + 5;

  logic clk_i = 1'b0;
  logic rst_i, start_i, mode_i;
  logic busy_o, done_o, rd_en_o, ct_mode_o, wr_en_o;
  logic [ADDR_W-1:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;

  ntt_scheduler #(.LOGN(LOGN), .BFU_LAT(BFU_LAT), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
    .ct_mode_o(ct_mode_o), .wr_en_o(wr_en_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    bit busy, done, ct, rd_en;
    int ra, rb, tw;
    bit wr_en;
    int wa, wb;
  } outs_t;
  typedef struct { bit mode; int cyc; outs_t e; } vec_t;
  typedef struct { int a, b, tw; } trio_t;

  vec_t  tbl[$];
  trio_t gold[$], obs_rd[$], obs_wr[$];
  int    wcount[N];
  int    hazards;

  logic [VW-1:0] act;
  assign act = {busy_o, done_o, ct_mode_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
                wr_en_o, wr_addr_a_o, wr_addr_b_o};

  function automatic logic [VW-1:0] pack(outs_t o);
    return {o.busy, o.done, o.ct, o.rd_en, ADDR_W'(o.ra), ADDR_W'(o.rb), ADDR_W'(o.tw),
            o.wr_en, ADDR_W'(o.wa), ADDR_W'(o.wb)};
  endfunction

  function automatic vec_t mk(bit m, int c, bit bz, bit dn, bit ct, bit rd, int ra, int rb,
                              int tw, bit wr, int wa, int wb);
    vec_t v;
    v.mode = m; v.cyc = c;
    v.e.busy = bz; v.e.done = dn; v.e.ct = ct; v.e.rd_en = rd;
    v.e.ra = ra; v.e.rb = rb; v.e.tw = tw;
    v.e.wr_en = wr; v.e.wa = wa; v.e.wb = wb;
    return v;
  endfunction

  // Which butterfly (if any) is read at relative cycle t, from the stage/offset arithmetic.
  function automatic bit read_at(int t, bit m, output int ra, output int rb, output int tw);
    int s, b, len, g, o;
    ra = 0; rb = 0; tw = 0;
    if (t < 1) return 1'b0;
    s = (t - 1) / P;
    b = (t - 1) % P;
    if (s >= LOGN || b >= HALF) return 1'b0;
    len = m ? (1 << s) : (N >> (s + 1));
    g = b / len;
    o = b % len;
    ra = 2 * g * len + o;
    rb = ra + len;
    tw = m ? ((N >> s) - 1 - g) : ((1 << s) + g);
    return 1'b1;
  endfunction

  function automatic outs_t model(int t, bit m);
    outs_t e;
    int ra, rb, tw;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).e;
    if (t >= 1 && t <= TOT) begin e.busy = 1'b1; e.ct = !m; end
    if (t == TOT + 1) begin e.done = 1'b1; e.ct = !m; end
    if (read_at(t, m, ra, rb, tw)) begin e.rd_en = 1'b1; e.ra = ra; e.rb = rb; e.tw = tw; end
    if (read_at(t - D, m, ra, rb, tw)) begin e.wr_en = 1'b1; e.wa = ra; e.wb = rb; end
    return e;
  endfunction

  task automatic check(string nm, int t, logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cmp_cycle(int t, bit m);
    check("model", t, pack(model(t, m)));
    foreach (tbl[i])
      if (tbl[i].mode == m && tbl[i].cyc == t) check("table", t, pack(tbl[i].e));
  endtask

  task automatic sample();
    trio_t x;
    int stage;
    if (rd_en_o) begin
      stage = obs_rd.size() / HALF;
      if (wcount[rd_addr_a_o] != stage || wcount[rd_addr_b_o] != stage) hazards++;
      x.a = int'(rd_addr_a_o); x.b = int'(rd_addr_b_o); x.tw = int'(tw_addr_o);
      obs_rd.push_back(x);
    end
    if (wr_en_o) begin
      wcount[wr_addr_a_o]++;
      wcount[wr_addr_b_o]++;
      x.a = int'(wr_addr_a_o); x.b = int'(wr_addr_b_o); x.tw = 0;
      obs_wr.push_back(x);
    end
  endtask

  task automatic build_gold(bit m);
    int k;
    trio_t x;
    gold.delete();
    if (!m) begin
      k = 1;
      for (int len = HALF; len >= 1; len = len / 2)
        for (int st = 0; st < N; st += 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            x.a = j; x.b = j + len; x.tw = k;
            gold.push_back(x);
          end
          k++;
        end
    end else begin
      k = N - 1;
      for (int len = 1; len < N; len = len * 2)
        for (int st = 0; st < N; st += 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            x.a = j; x.b = j + len; x.tw = k;
            gold.push_back(x);
          end
          k--;
        end
    end
  endtask

  task automatic final_check(bit m);
    int bad, first;
    build_gold(m);
    bad = 0; first = -1;
    n_cmp++;
    if (obs_rd.size() != gold.size()) bad = 1;
    else for (int i = 0; i < gold.size(); i++)
      if (obs_rd[i].a != gold[i].a || obs_rd[i].b != gold[i].b || obs_rd[i].tw != gold[i].tw) begin
        bad++; if (first < 0) first = i;
      end
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rd_order mode=%0d actual_reads=%0d wrong=%0d first=%0d required_reads=%0d",
               m, obs_rd.size(), bad, first, gold.size());
    end
    bad = 0; first = -1;
    n_cmp++;
    if (obs_wr.size() != gold.size()) bad = 1;
    else for (int i = 0; i < gold.size(); i++)
      if (obs_wr[i].a != gold[i].a || obs_wr[i].b != gold[i].b) begin
        bad++; if (first < 0) first = i;
      end
    if (bad != 0) begin
      n_bad++;
      $display("FAIL wr_order mode=%0d actual_writes=%0d wrong=%0d first=%0d required_writes=%0d",
               m, obs_wr.size(), bad, first, gold.size());
    end
    n_cmp++;
    if (hazards != 0) begin
      n_bad++;
      $display("FAIL stage_hazard actual=%0d required=0", hazards);
    end
    bad = 0;
    for (int i = 0; i < N; i++) if (wcount[i] != LOGN) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL write_count addresses_wrong=%0d required=0 (each written %0d times)", bad, LOGN);
    end
  endtask

  task automatic clear_sb();
    obs_rd.delete();
    obs_wr.delete();
    for (int i = 0; i < N; i++) wcount[i] = 0;
    hazards = 0;
  endtask

  // Starts in the cycle where start is presented; ends in the cycle after done.
  task automatic run_transform(bit m, bit hold, bit noise, int poke);
    clear_sb();
    start_i = 1'b1;
    mode_i  = m;
    for (int t = 0; t <= TOT + 1; t++) begin
      cmp_cycle(t, m);
      sample();
      if (t >= 1) begin
        start_i = hold;
        mode_i  = m;
        if (noise) begin start_i = 1'($urandom); mode_i = 1'($urandom); end
        if (t == poke) begin start_i = 1'b1; mode_i = !m; end
      end
      step();
    end
    if (!hold) start_i = 1'b0;
    final_check(m);
  endtask

  task automatic idle_check(int n);
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      mode_i = 1'($urandom);
      check("idle", i, '0);
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;

    // forward spot checks
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0, 0,   0,   0, 0,   0));
    tbl.push_back(mk(0, 1,    1, 0, 1, 1, 0, 128, 1,   0, 0,   0));
    tbl.push_back(mk(0, 2,    1, 0, 1, 1, 1, 129, 1,   0, 0,   0));
    tbl.push_back(mk(0, 6,    1, 0, 1, 1, 5, 133, 1,   1, 0,   128));
    tbl.push_back(mk(0, 133,  1, 0, 1, 0, 0, 0,   0,   1, 127, 255));
    tbl.push_back(mk(0, 134,  1, 0, 1, 1, 0, 64,  2,   0, 0,   0));
    tbl.push_back(mk(0, 932,  1, 0, 1, 1, 0, 1,   128, 0, 0,   0));
    tbl.push_back(mk(0, 1064, 1, 0, 1, 0, 0, 0,   0,   1, 254, 255));
    tbl.push_back(mk(0, 1065, 0, 1, 1, 0, 0, 0,   0,   0, 0,   0));
    // inverse spot checks
    tbl.push_back(mk(1, 1,    1, 0, 0, 1, 0, 1,   255, 0, 0,   0));
    tbl.push_back(mk(1, 2,    1, 0, 0, 1, 2, 3,   254, 0, 0,   0));
    tbl.push_back(mk(1, 6,    1, 0, 0, 1, 10, 11, 250, 1, 0,   1));
    tbl.push_back(mk(1, 134,  1, 0, 0, 1, 0, 2,   127, 0, 0,   0));
    tbl.push_back(mk(1, 932,  1, 0, 0, 1, 0, 128, 1,   0, 0,   0));
    tbl.push_back(mk(1, 1064, 1, 0, 0, 0, 0, 0,   0,   1, 127, 255));
    tbl.push_back(mk(1, 1065, 0, 1, 0, 0, 0, 0,   0,   0, 0,   0));

    // reset then idle
    #1;
    check("reset", 0, '0);
    step();
    step();
    check("reset", 2, '0);
    rst_i = 1'b0;
    idle_check(20);

    run_transform(1'b0, 1'b0, 1'b0, -1);
    idle_check(3);
    run_transform(1'b1, 1'b0, 1'b0, -1);
    idle_check(3);

    // start/mode poke while busy
    run_transform(1'b0, 1'b0, 1'b0, 500);
    idle_check(3);

    // reset mid-transform
    start_i = 1'b1;
    mode_i  = 1'b0;
    for (int t = 0; t < 300; t++) begin
      cmp_cycle(t, 1'b0);
      if (t >= 1) start_i = 1'b0;
      step();
    end
    cmp_cycle(300, 1'b0);
    rst_i = 1'b1;
    #1;
    check("rst_mid", 300, '0);
    step();
    check("rst_mid", 301, '0);
    step();
    rst_i = 1'b0;
    idle_check(20);
    run_transform(1'b0, 1'b0, 1'b0, -1);
    idle_check(3);

    // back-to-back with start held high
    run_transform(1'b0, 1'b1, 1'b0, -1);
    run_transform(1'b1, 1'b0, 1'b0, -1);
    idle_check(3);

    // random gaps, random mode, random start/mode noise while busy
    for (int r = 0; r < 3; r++) begin
      idle_check($urandom_range(0, 5));
      run_transform(1'($urandom), 1'b0, 1'b1, -1);
    end
    idle_check(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
